// File: rtl/sqrt_fp_param_if.sv
// Control and flag bundle for sqrt_fp_param. IO_DATA remains a plain inout on the block.
// The macro SQRT_INEXACT_FLAG_EN adds the IS_INEXACT flag.
interface sqrt_fp_param_if;
   logic ENABLE;
   logic RESULT;
   logic IS_NAN;
   logic IS_PINF;
   logic IS_NINF;
`ifdef SQRT_INEXACT_FLAG_EN
   logic IS_INEXACT;

   modport master (output ENABLE, input RESULT, input IS_NAN, input IS_PINF, input IS_NINF,
                   input IS_INEXACT);
   modport slave  (input ENABLE, output RESULT, output IS_NAN, output IS_PINF, output IS_NINF,
                   output IS_INEXACT);
`else
   modport master (output ENABLE, input RESULT, input IS_NAN, input IS_PINF, input IS_NINF);
   modport slave  (input ENABLE, output RESULT, output IS_NAN, output IS_PINF, output IS_NINF);
`endif
endinterface

// File: rtl/sqrt_fp_param.sv
// Iterative IEEE-754 square root (restoring recurrence, RNE) with a shared bidirectional IO_DATA bus.
// The macro SQRT_INEXACT_FLAG_EN adds IS_INEXACT (guard|sticky of the rounded result).
module sqrt_fp_param #(
   parameter int unsigned EXP_W          = 5,
   parameter int unsigned MAN_W          = 10,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   sqrt_fp_param_if.slave         io_ctl,
   inout  wire  [EXP_W+MAN_W:0]   IO_DATA
);
   localparam int unsigned W    = 1 + EXP_W + MAN_W;
   localparam int unsigned NR   = MAN_W + 2;
   localparam int unsigned RW   = NR + 3;
   localparam int unsigned CW   = $clog2(NR + BITS_PER_CYCLE + 1);
   localparam int unsigned LZW  = $clog2(MAN_W + 1);
   localparam int unsigned EW2  = EXP_W + LZW + 2;
   localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_ROUND, S_DONE} state_t;

   state_t           r_state;
   logic             r_armed;
   logic [W-1:0]     r_op;
   logic [W-1:0]     r_res;
   logic [2*NR-1:0]  r_rad;
   logic [RW-1:0]    r_rem;
   logic [NR-1:0]    r_root;
   logic [CW-1:0]    r_step;
   logic [EXP_W-1:0] r_exp;
   logic             r_result;
   logic             r_nan;
   logic             r_pinf;
`ifdef SQRT_INEXACT_FLAG_EN
   logic             r_inexact;
`endif

   logic                  w_sign, w_exp_max, w_exp_zero, w_man_zero;
   logic                  w_is_nan, w_is_zero, w_is_pinf, w_special;
   logic [EXP_W-1:0]      w_exp_f;
   logic [MAN_W-1:0]      w_man_f;
   logic [LZW-1:0]        w_lz, w_shamt;
   logic                  w_found;
   logic [MAN_W:0]        w_sig_norm;
   logic [MAN_W+1:0]      w_sig2;
   logic signed [EW2-1:0] w_e_unb, w_e_res;
   logic [W-1:0]          w_spec_res;
   logic [RW-1:0]         w_rem_n, w_rem_sh;
   logic [NR+1:0]         w_trial;
   logic [NR-1:0]         w_root_n;
   logic [2*NR-1:0]       w_rad_n;
   logic                  w_guard, w_sticky, w_rnd_up;
   logic [MAN_W:0]        w_man_rnd;
   logic [EXP_W-1:0]      w_exp_rnd;

   assign w_sign     = r_op[W-1];
   assign w_exp_f    = r_op[W-2 -: EXP_W];
   assign w_man_f    = r_op[MAN_W-1:0];
   assign w_exp_max  = &w_exp_f;
   assign w_exp_zero = ~|w_exp_f;
   assign w_man_zero = ~|w_man_f;
   assign w_is_nan   = w_exp_max & ~w_man_zero;
   assign w_is_zero  = w_exp_zero & w_man_zero;
   assign w_is_pinf  = w_exp_max & w_man_zero & ~w_sign;
   assign w_special  = w_is_nan | w_is_zero | w_is_pinf | w_sign;

   always_comb begin
      w_lz    = '0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < MAN_W; i++) begin
         if (!w_found && !w_man_f[MAN_W-1-i]) w_lz = w_lz + 1'b1;
         else                                  w_found = 1'b1;
      end
   end

   // Subnormals shift past the hidden-bit position, hence lz+1.
   assign w_shamt = w_lz + 1'b1;

   always_comb begin
      if (w_exp_zero) begin
         w_sig_norm = {1'b0, w_man_f} << w_shamt;
         w_e_unb    = EW2'(1) - EW2'(BIAS) - EW2'(w_shamt);
      end else begin
         w_sig_norm = {1'b1, w_man_f};
         w_e_unb    = EW2'(w_exp_f) - EW2'(BIAS);
      end
      w_sig2  = w_e_unb[0] ? {w_sig_norm, 1'b0} : {1'b0, w_sig_norm};
      w_e_res = (w_e_unb >>> 1) + EW2'(BIAS);
   end

   always_comb begin
      if (w_is_nan)                    w_spec_res = r_op | (W'(1) << (MAN_W - 1));
      else if (w_is_zero || w_is_pinf) w_spec_res = r_op;
      else                             w_spec_res = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   end

   // Unrolled restoring stages; stages beyond the last root bit pass state through.
   always_comb begin
      w_rem_n  = r_rem;
      w_root_n = r_root;
      w_rad_n  = r_rad;
      w_rem_sh = '0;
      w_trial  = '0;
      for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
         if ((32'(r_step) + j) < NR) begin
            w_rem_sh = {w_rem_n[RW-3:0], w_rad_n[2*NR-1 -: 2]};
            w_trial  = {w_root_n, 2'b01};
            if (w_rem_sh >= RW'(w_trial)) begin
               w_rem_n  = w_rem_sh - RW'(w_trial);
               w_root_n = {w_root_n[NR-2:0], 1'b1};
            end else begin
               w_rem_n  = w_rem_sh;
               w_root_n = {w_root_n[NR-2:0], 1'b0};
            end
            w_rad_n = {w_rad_n[2*NR-3:0], 2'b00};
         end
      end
   end

   assign w_guard   = r_root[0];
   assign w_sticky  = |r_rem;
   assign w_rnd_up  = w_guard & (w_sticky | r_root[1]);
   assign w_man_rnd = {1'b0, r_root[MAN_W:1]} + (MAN_W+1)'(w_rnd_up);
   assign w_exp_rnd = r_exp + EXP_W'(w_man_rnd[MAN_W]);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state  <= S_IDLE;
         r_armed  <= 1'b0;
         r_op     <= '0;
         r_res    <= '0;
         r_rad    <= '0;
         r_rem    <= '0;
         r_root   <= '0;
         r_step   <= '0;
         r_exp    <= '0;
         r_result <= 1'b0;
         r_nan    <= 1'b0;
         r_pinf   <= 1'b0;
`ifdef SQRT_INEXACT_FLAG_EN
         r_inexact <= 1'b0;
`endif
      end else if (!io_ctl.ENABLE) begin
         r_state  <= S_IDLE;
         r_armed  <= 1'b1;
         r_result <= 1'b0;
         r_nan    <= 1'b0;
         r_pinf   <= 1'b0;
`ifdef SQRT_INEXACT_FLAG_EN
         r_inexact <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_armed) begin
                  r_op    <= IO_DATA;
                  r_armed <= 1'b0;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_special) begin
                  r_res    <= w_spec_res;
                  r_nan    <= ~w_is_zero & ~w_is_pinf;
                  r_pinf   <= w_is_pinf;
                  r_result <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_rad   <= {w_sig2, (MAN_W+2)'(0)};
                  r_rem   <= '0;
                  r_root  <= '0;
                  r_step  <= '0;
                  r_exp   <= EXP_W'(w_e_res);
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_rem  <= w_rem_n;
               r_root <= w_root_n;
               r_rad  <= w_rad_n;
               r_step <= r_step + CW'(BITS_PER_CYCLE);
               if ((32'(r_step) + BITS_PER_CYCLE) >= NR) r_state <= S_ROUND;
            end
            S_ROUND: begin
               r_res    <= {1'b0, w_exp_rnd, w_man_rnd[MAN_W-1:0]};
               r_result <= 1'b1;
`ifdef SQRT_INEXACT_FLAG_EN
               r_inexact <= w_guard | w_sticky;
`endif
               r_state  <= S_DONE;
            end
            S_DONE:  r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign IO_DATA        = (r_result && io_ctl.ENABLE) ? r_res : 'z;
   assign io_ctl.RESULT  = r_result;
   assign io_ctl.IS_NAN  = r_nan;
   assign io_ctl.IS_PINF = r_pinf;
   assign io_ctl.IS_NINF = 1'b0;
`ifdef SQRT_INEXACT_FLAG_EN
   assign io_ctl.IS_INEXACT = r_inexact;
`endif
endmodule
